// File: rtl/key_schedule_ctrl.sv
// Iterative AES-128 key-schedule controller: one shared key_gen round per cycle,
// all NR+1 round keys banked and served by index to the inverse-cipher datapath.

// One AES-128 key-expansion round, purely combinational; S-box derived from GF(2^8) inverse.
module key_gen #(
   parameter int KW = 128
) (
   input  logic [3:0]    rnd,
   input  logic [KW-1:0] key,
   output logic [KW-1:0] key_nxt
);
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] s;
      logic [7:0] b;
      // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
      r = 8'h01;
      s = a;
      for (int i = 1; i < 8; i++) begin
         s = gf_mul(s, s);
         r = gf_mul(r, s);
      end
      b = r;
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   logic [7:0]  rcon;
   logic [31:0] w0, w1, w2, w3, rot, temp;

   always_comb begin
      rcon = 8'h00;
      case (rnd)
         4'd0: rcon = 8'h01;
         4'd1: rcon = 8'h02;
         4'd2: rcon = 8'h04;
         4'd3: rcon = 8'h08;
         4'd4: rcon = 8'h10;
         4'd5: rcon = 8'h20;
         4'd6: rcon = 8'h40;
         4'd7: rcon = 8'h80;
         4'd8: rcon = 8'h1b;
         4'd9: rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   end

   assign w0   = key[127:96];
   assign w1   = key[95:64];
   assign w2   = key[63:32];
   assign w3   = key[31:0];
   assign rot  = {w3[23:0], w3[31:24]};
   assign temp = {sbox(rot[31:24]) ^ rcon, sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

   assign key_nxt[127:96] = w0 ^ temp;
   assign key_nxt[95:64]  = w1 ^ w0 ^ temp;
   assign key_nxt[63:32]  = w2 ^ w1 ^ w0 ^ temp;
   assign key_nxt[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ temp;
endmodule

// state  | meaning
// IDLE   | no schedule held; waiting for a cipher key
// EXPAND | generating round keys 1..NR, one per cycle
// DONE   | full schedule banked and readable; a new key restarts expansion
module key_schedule_ctrl #(
   parameter int NR = 10,
   parameter int KW = 128
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          key_valid,
   input  logic [KW-1:0] key_in,
   output logic          key_ready,
   output logic          busy,
   output logic          keys_valid,
   input  logic          rd_en,
   input  logic [3:0]    rd_idx,
   output logic [KW-1:0] rd_data,
   output logic          rd_valid,
   output logic          rd_err
);
   typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

   state_t        state, state_nxt;
   logic          load;
   logic [3:0]    cnt;
   logic [KW-1:0] work;
   logic [KW-1:0] kg_out;
   logic [KW-1:0] bank [NR+1];

   key_gen #(.KW(KW)) u_key_gen (
      .rnd     (cnt),
      .key     (work),
      .key_nxt (kg_out)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      key_ready = 1'b0;
      busy      = 1'b0;
      load      = 1'b0;
      case (state)
         IDLE, DONE: begin
            key_ready = 1'b1;
            if (key_valid) begin
               load      = 1'b1;
               state_nxt = EXPAND;
            end
         end
         EXPAND: begin
            busy = 1'b1;
            if (cnt == 4'(NR - 1)) state_nxt = DONE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Only DONE exposes the bank, so a partial schedule is never readable
   assign keys_valid = (state == DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt  <= '0;
         work <= '0;
         for (int i = 0; i <= NR; i++) bank[i] <= '0;
      end else if (load) begin
         bank[0] <= key_in;
         work    <= key_in;
         cnt     <= '0;
      end else if (state == EXPAND) begin
         bank[cnt + 4'd1] <= kg_out;
         work             <= kg_out;
         cnt              <= cnt + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
      end else begin
         rd_valid <= 1'b0;
         rd_err   <= 1'b0;
         if (rd_en) begin
            if (keys_valid && (rd_idx <= 4'(NR))) begin
               rd_data  <= bank[rd_idx];
               rd_valid <= 1'b1;
            end else begin
               rd_err <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Scoreboard bench for key_schedule_ctrl: reads push expected results, a negedge monitor checks them.
module tb_key_schedule_ctrl;
   localparam int NR = 10;
   localparam int KW = 128;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          key_valid = 1'b0;
   logic [KW-1:0] key_in = '0;
   logic          key_ready, busy, keys_valid;
   logic          rd_en = 1'b0;
   logic [3:0]    rd_idx = '0;
   logic [KW-1:0] rd_data;
   logic          rd_valid, rd_err;

   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      logic          err;
      logic [KW-1:0] data;
   } exp_t;
   exp_t exp_q[$];
   logic [KW-1:0] last_data = '0;

   logic [KW-1:0] fips [NR+1];
   logic [KW-1:0] zero_rk10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
   logic [KW-1:0] fips_key  = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   key_schedule_ctrl #(.NR(NR), .KW(KW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_valid  (key_valid),
      .key_in     (key_in),
      .key_ready  (key_ready),
      .busy       (busy),
      .keys_valid (keys_valid),
      .rd_en      (rd_en),
      .rd_idx     (rd_idx),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_err     (rd_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [KW-1:0] act, input logic [KW-1:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   // Monitor: pops one expectation per rd_valid/rd_err pulse
   always @(negedge clk) begin
      if (rst_n && (rd_valid || rd_err)) begin
         exp_t e;
         vectors++;
         if (rd_valid && rd_err) begin
            miscompares++;
            $display("FAIL rd_both: rd_valid and rd_err high together");
         end else if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL rd_unexpected: valid=%0b err=%0b data=%h with no read pending",
                     rd_valid, rd_err, rd_data);
         end else begin
            e = exp_q.pop_front();
            if (rd_err !== e.err || rd_data !== e.data) begin
               miscompares++;
               $display("FAIL rd_result: got err=%0b data=%h expected err=%0b data=%h",
                        rd_err, rd_data, e.err, e.data);
            end
         end
      end
   end

   // Issues a read for the coming edge and records its expected result; caller clears rd_en
   task automatic issue_read(input logic [3:0] idx, input logic err, input logic [KW-1:0] data);
      exp_t e;
      e.err  = err;
      e.data = err ? last_data : data;
      if (!err) last_data = data;
      exp_q.push_back(e);
      rd_en  = 1'b1;
      rd_idx = idx;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic read(input logic [3:0] idx, input logic err, input logic [KW-1:0] data);
      issue_read(idx, err, data);
      step();
      rd_en = 1'b0;
   endtask

   // Handshake then measure the busy window; hold keeps offering a different key during EXPAND
   task automatic load_key(input logic [KW-1:0] k, input logic hold);
      int cycles;
      check("key_ready_before_load", key_ready, 1);
      key_valid = 1'b1;
      key_in    = k;
      step();
      rd_en = 1'b0;
      check("keys_valid_at_handshake", keys_valid, 0);
      if (hold) key_in = ~k;
      else      key_valid = 1'b0;
      cycles = 0;
      while (busy && cycles < 40) begin
         cycles++;
         if (key_ready !== 1'b0) begin
            vectors++;
            miscompares++;
            $display("FAIL key_ready_in_expand: got %0b expected 0", key_ready);
         end
         step();
      end
      key_valid = 1'b0;
      check("busy_cycles", 128'(cycles), 128'(NR));
      check("keys_valid_after_expand", keys_valid, 1);
      check("key_ready_in_done", key_ready, 1);
   endtask

   initial begin
      fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
      fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

      #12;
      check("rst_key_ready", key_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_keys_valid", keys_valid, 0);
      check("rst_rd_data", rd_data, 0);
      rst_n = 1'b1;
      step();
      read(4'd0, 1'b1, '0);

      // FIPS key while holding key_valid with a different key through EXPAND
      load_key(fips_key, 1'b1);
      step();
      check("no_rekey_after_hold", busy, 0);
      read(4'd0, 1'b0, fips[0]);
      read(4'd1, 1'b0, fips[1]);
      read(4'd10, 1'b0, fips[10]);
      read(4'd11, 1'b1, '0);
      read(4'd15, 1'b1, '0);

      for (int i = NR; i >= 0; i--) issue_read_step(4'(i));
      rd_en = 1'b0;
      step();

      // Rekey to zero with a read landing on the handshake edge
      issue_read(4'd10, 1'b0, fips[10]);
      load_key('0, 1'b0);
      read(4'd10, 1'b0, zero_rk10);
      read(4'd0, 1'b0, '0);

      // Abort on the 5th EXPAND cycle
      key_valid = 1'b1;
      key_in    = fips_key;
      step();
      key_valid = 1'b0;
      repeat (4) step();
      check("busy_before_abort", busy, 1);
      rst_n = 1'b0;
      #1;
      last_data = '0;
      check("abort_busy", busy, 0);
      check("abort_keys_valid", keys_valid, 0);
      check("abort_key_ready", key_ready, 1);
      check("abort_rd_data", rd_data, 0);
      check("abort_rd_valid", rd_valid, 0);
      step();
      rst_n = 1'b1;
      step();
      read(4'd10, 1'b1, '0);
      load_key(fips_key, 1'b0);
      read(4'd10, 1'b0, fips[10]);
      read(4'd5, 1'b0, fips[5]);

      step();
      step();
      check("scoreboard_drained", 128'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   task automatic issue_read_step(input logic [3:0] idx);
      issue_read(idx, 1'b0, fips[idx]);
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule

// File: doc/key_schedule_ctrl.md
Name: key_schedule_ctrl

Overview:
Iterative AES-128 key-schedule controller for the decryption path. It accepts a cipher key over a valid/ready handshake and drives a single shared key_gen instance, one round per cycle. It stores all NR+1 round keys in an internal bank and serves them by round index to the inverse-cipher datapath, which reads them in reverse order (10 down to 0). It replaces the fully unrolled 10-instance expansion with one key_gen plus sequencing.

Parameters:
NR, 10, number of rounds; the bank holds NR+1 keys; round index width is 4 bits.
KW, 128, key and round-key width in bits.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
key_valid  input  1  cipher key offered.
key_in  input  KW  cipher key; sampled on handshake.
key_ready  output  1  controller can accept a key.
busy  output  1  expansion in progress.
keys_valid  output  1  all NR+1 round keys stored and readable.
rd_en  input  1  round-key read request.
rd_idx  input  4  round index, 0..NR.
rd_data  output  KW  registered round key.
rd_valid  output  1  rd_data updated this cycle; 1-cycle pulse.
rd_err  output  1  rejected read; 1-cycle pulse.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; key_ready=1; busy=0; keys_valid=0.
  - rd_valid=0; rd_err=0; rd_data=0.
  - Round counter=0; working key register=0; all bank entries=0.
- FSM states:
  - IDLE: key_ready=1. On key_valid&&key_ready at edge T: bank[0]<=key_in; work<=key_in; cnt<=0; go to EXPAND.
  - EXPAND: key_ready=0, busy=1. Each edge: bank[cnt+1]<=kg_out; work<=kg_out; cnt<=cnt+1. kg_out is the key_gen output with round input=cnt (0..NR-1) and key input=work. The edge with cnt==NR-1 writes bank[NR], sets keys_valid=1 and goes to DONE.
  - DONE: key_ready=1, busy=0, keys_valid=1. A new handshake behaves as in IDLE, clears keys_valid at the same edge and goes to EXPAND (rekey).
- Latency: handshake at edge T gives keys_valid=1 after edge T+NR. busy is high for exactly NR cycles.
- key_valid while key_ready=0 is ignored. No buffering; the source must hold the key until the handshake.
- key_gen is purely combinational. The round index is a zero-extended 4-bit cnt.
- Reads:
  - rd_en with keys_valid=1 and rd_idx<=NR: at next edge rd_data<=bank[rd_idx], rd_valid=1.
  - rd_en with rd_idx>NR, or with keys_valid=0: at next edge rd_err=1, rd_valid=0, rd_data holds its value.
  - rd_valid and rd_err are never both high. Back-to-back reads give one result per cycle.
  - A read issued on the same edge as a rekey handshake uses the pre-edge keys_valid (=1), so it is served with the old key.
- Any order of rd_idx is legal; the decryption core uses NR..0.
- rst_n low at any time, including mid-EXPAND, aborts immediately to reset values. A partial schedule is never exposed.

Test Plan:
- Reset -> key_ready=1, busy=0, keys_valid=0, rd_data=0. rd_en with idx 0 -> rd_err pulse and rd_valid=0.
- Load key 2b7e151628aed2a6abf7158809cf4f3c -> busy high 10 cycles, keys_valid rises 10 edges after the handshake. Reads: idx0=2b7e1516...09cf4f3c, idx1=a0fafe1788542cb123a339392a6c7605, idx10=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Hold key_valid=1 with a different key throughout EXPAND -> key_ready=0, ignored. Round-10 key still d014f9a8...
- From DONE, rekey with the all-zero key -> keys_valid drops at the handshake edge, re-rises 10 edges later. idx10=b4ef5bcb3e92e21123e951cf6f8f188e. A read issued on the handshake edge returns the old d014... key.
- rd_idx=11 and rd_idx=15 with keys_valid=1 -> rd_err pulse, rd_data unchanged. Reverse sweep 10..0 on consecutive cycles -> 11 consecutive rd_valid pulses with the correct keys.
- Assert rst_n=0 on the 5th EXPAND cycle -> all outputs and bank return to reset values. Reload the FIPS key -> the correct schedule completes in 10 cycles.
